// File: rtl/nes_ppu_pkg.sv
// Shared types and widths for the background tile fetch path.
package nes_ppu_pkg;

  localparam int NT_AW = 11;
  localparam int AT_AW = 7;
  localparam int PT_AW = 13;

  localparam logic [4:0] MAX_ROW = 5'd29;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    NT   = 3'd1,
    AT   = 3'd2,
    PLO  = 3'd3,
    PHI  = 3'd4,
    DONE = 3'd5
  } fetch_state_t;

endpackage

// File: rtl/nes_bg_tile_fetch_ctrl_if.sv
// ROM bus between the tile fetch controller (master) and the background ROM set (slave).
interface nes_bg_tile_fetch_ctrl_if;
  import nes_ppu_pkg::*;

  logic [NT_AW-1:0] nt_addr;
  logic [7:0]       nt_data;
  logic [AT_AW-1:0] at_addr;
  logic [7:0]       at_data;
  logic [PT_AW-1:0] pt_addr;
  logic [7:0]       pt_data;

  modport master (
    output nt_addr, at_addr, pt_addr,
    input  nt_data, at_data, pt_data
  );

  modport slave (
    input  nt_addr, at_addr, pt_addr,
    output nt_data, at_data, pt_data
  );

endinterface

// File: rtl/nes_attr_quadrant_sel.sv
// Picks the 2-bit palette for one 16x16 quadrant out of an attribute byte.
module nes_attr_quadrant_sel (
  input  logic [7:0] at_byte,
  input  logic       row1,
  input  logic       col1,
  output logic [1:0] pal
);

  always_comb begin
    pal = at_byte[1:0];
    case ({row1, col1})
      2'b00: pal = at_byte[1:0];
      2'b01: pal = at_byte[3:2];
      2'b10: pal = at_byte[5:4];
      2'b11: pal = at_byte[7:6];
      default: pal = at_byte[1:0];
    endcase
  end

endmodule

// File: rtl/nes_bg_tile_fetch_ctrl.sv
// Walks name table, attribute and both pattern planes for one tile and
// presents the assembled record with a single-cycle done pulse.
module nes_bg_tile_fetch_ctrl
  import nes_ppu_pkg::*;
(
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            start,
  input  logic                            nt_sel,
  input  logic                            pt_sel,
  input  logic [4:0]                      tile_col,
  input  logic [4:0]                      tile_row,
  input  logic [2:0]                      fine_y,
  nes_bg_tile_fetch_ctrl_if.master        rom,
  output logic                            busy,
  output logic                            done,
  output logic [7:0]                      tile_idx,
  output logic [1:0]                      tile_pal,
  output logic [7:0]                      tile_pat_lo,
  output logic [7:0]                      tile_pat_hi,
  output logic                            oor
);

  fetch_state_t state_reg, state_next;

  logic       nt_sel_reg;
  logic       pt_sel_reg;
  logic [4:0] col_reg;
  logic [4:0] row_reg;
  logic [2:0] fy_reg;
  logic       oor_reg;
  logic [7:0] idx_reg;
  logic [1:0] pal_reg;
  logic [7:0] lo_reg;
  logic [7:0] hi_reg;

  logic             accept;
  logic [1:0]       pal_next;
  logic [NT_AW-1:0] nt_addr_next;
  logic [AT_AW-1:0] at_addr_next;
  logic [PT_AW-1:0] pt_addr_next;

  assign accept = (state_reg == IDLE) && start;

  nes_attr_quadrant_sel u_quad (
    .at_byte (rom.at_data),
    .row1    (row_reg[1]),
    .col1    (col_reg[1]),
    .pal     (pal_next)
  );

  always_comb begin
    state_next   = state_reg;
    nt_addr_next = '0;
    at_addr_next = '0;
    pt_addr_next = '0;
    case (state_reg)
      IDLE: if (start) state_next = NT;
      NT: begin
        nt_addr_next = {nt_sel_reg, row_reg, col_reg};
        state_next   = AT;
      end
      AT: begin
        at_addr_next = {nt_sel_reg, row_reg[4:2], col_reg[4:2]};
        state_next   = PLO;
      end
      PLO: begin
        pt_addr_next = {pt_sel_reg, idx_reg, 1'b0, fy_reg};
        state_next   = PHI;
      end
      PHI: begin
        pt_addr_next = {pt_sel_reg, idx_reg, 1'b1, fy_reg};
        state_next   = DONE;
      end
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= IDLE;
      nt_sel_reg <= 1'b0;
      pt_sel_reg <= 1'b0;
      col_reg    <= '0;
      row_reg    <= '0;
      fy_reg     <= '0;
      oor_reg    <= 1'b0;
      idx_reg    <= '0;
      pal_reg    <= '0;
      lo_reg     <= '0;
      hi_reg     <= '0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        nt_sel_reg <= nt_sel;
        pt_sel_reg <= pt_sel;
        col_reg    <= tile_col;
        row_reg    <= tile_row;
        fy_reg     <= fine_y;
        oor_reg    <= (tile_row > MAX_ROW);
      end
      // Out-of-range requests keep the ROM walk but record zeros instead of data.
      case (state_reg)
        NT:  idx_reg <= oor_reg ? 8'h00 : rom.nt_data;
        AT:  pal_reg <= oor_reg ? 2'b00 : pal_next;
        PLO: lo_reg  <= oor_reg ? 8'h00 : rom.pt_data;
        PHI: hi_reg  <= oor_reg ? 8'h00 : rom.pt_data;
        default: ;
      endcase
    end
  end

  assign rom.nt_addr = nt_addr_next;
  assign rom.at_addr = at_addr_next;
  assign rom.pt_addr = pt_addr_next;

  assign busy        = (state_reg != IDLE);
  assign done        = (state_reg == DONE);
  assign tile_idx    = idx_reg;
  assign tile_pal    = pal_reg;
  assign tile_pat_lo = lo_reg;
  assign tile_pat_hi = hi_reg;
  assign oor         = oor_reg;

endmodule

// File: tb/tb_nes_bg_tile_fetch_ctrl.sv
// Directed bench for the background tile fetch controller with behavioural ROMs.
module tb_nes_bg_tile_fetch_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       nt_sel = 1'b0;
  logic       pt_sel = 1'b0;
  logic [4:0] tile_col = '0;
  logic [4:0] tile_row = '0;
  logic [2:0] fine_y = '0;
  logic       busy;
  logic       done;
  logic [7:0] tile_idx;
  logic [1:0] tile_pal;
  logic [7:0] tile_pat_lo;
  logic [7:0] tile_pat_hi;
  logic       oor;

  nes_bg_tile_fetch_ctrl_if rom_if ();

  logic [7:0] nt_mem [0:2047];
  logic [7:0] at_mem [0:127];
  logic [7:0] pt_mem [0:8191];

  assign rom_if.nt_data = nt_mem[rom_if.nt_addr];
  assign rom_if.at_data = at_mem[rom_if.at_addr];
  assign rom_if.pt_data = pt_mem[rom_if.pt_addr];

  nes_bg_tile_fetch_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .nt_sel      (nt_sel),
    .pt_sel      (pt_sel),
    .tile_col    (tile_col),
    .tile_row    (tile_row),
    .fine_y      (fine_y),
    .rom         (rom_if),
    .busy        (busy),
    .done        (done),
    .tile_idx    (tile_idx),
    .tile_pal    (tile_pal),
    .tile_pat_lo (tile_pat_lo),
    .tile_pat_hi (tile_pat_hi),
    .oor         (oor)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        nt_sel;
    logic        pt_sel;
    logic [4:0]  row;
    logic [4:0]  col;
    logic [2:0]  fy;
    logic [10:0] e_nt;
    logic [6:0]  e_at;
    logic [12:0] e_plo;
    logic [12:0] e_phi;
    logic [7:0]  e_idx;
    logic [1:0]  e_pal;
    logic [7:0]  e_lo;
    logic [7:0]  e_hi;
    logic        e_oor;
  } vec_t;

  vec_t vecs [0:6];

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v, input int k);
    logic early_done;
    early_done = 1'b0;
    @(negedge clk);
    nt_sel = v.nt_sel; pt_sel = v.pt_sel;
    tile_row = v.row; tile_col = v.col; fine_y = v.fy;
    start = 1'b1;
    @(negedge clk);  // NT
    start = 1'b0;
    nt_sel = ~v.nt_sel; pt_sel = ~v.pt_sel;
    tile_row = ~v.row; tile_col = ~v.col; fine_y = ~v.fy;
    early_done |= done;
    check("nt_addr", 32'(rom_if.nt_addr), 32'(v.e_nt));
    check("busy_nt", 32'(busy), 32'd1);
    check("oor_nt", 32'(oor), 32'(v.e_oor));
    @(negedge clk);  // AT
    early_done |= done;
    check("at_addr", 32'(rom_if.at_addr), 32'(v.e_at));
    check("idx_after_nt", 32'(tile_idx), 32'(v.e_idx));
    @(negedge clk);  // PLO
    early_done |= done;
    check("pt_addr_lo", 32'(rom_if.pt_addr), 32'(v.e_plo));
    check("pal_after_at", 32'(tile_pal), 32'(v.e_pal));
    @(negedge clk);  // PHI
    early_done |= done;
    check("pt_addr_hi", 32'(rom_if.pt_addr), 32'(v.e_phi));
    check("lo_after_plo", 32'(tile_pat_lo), 32'(v.e_lo));
    check("early_done", 32'(early_done), 32'd0);
    @(negedge clk);  // DONE, cycle N+5
    check("done_n5", 32'(done), 32'd1);
    check("busy_done", 32'(busy), 32'd1);
    check("tile_idx", 32'(tile_idx), 32'(v.e_idx));
    check("tile_pal", 32'(tile_pal), 32'(v.e_pal));
    check("tile_pat_lo", 32'(tile_pat_lo), 32'(v.e_lo));
    check("tile_pat_hi", 32'(tile_pat_hi), 32'(v.e_hi));
    check("oor", 32'(oor), 32'(v.e_oor));
    check("addr_zero_done", 32'({rom_if.nt_addr, rom_if.at_addr, rom_if.pt_addr}), 32'd0);
    @(negedge clk);  // back in IDLE
    check("done_pulse_end", 32'(done), 32'd0);
    check("busy_idle", 32'(busy), 32'd0);
    check("hold_hi", 32'(tile_pat_hi), 32'(v.e_hi));
    $display("fetch %0d row=%0d col=%0d idx=%02h pal=%0d lo=%02h hi=%02h oor=%0d", k, v.row, v.col,
             tile_idx, tile_pal, tile_pat_lo, tile_pat_hi, oor);
  endtask

  initial begin
    int done_cyc [0:2];
    int nd;
    logic seen_done;

    for (int i = 0; i < 2048; i++) nt_mem[i] = 8'h00;
    for (int i = 0; i < 128; i++)  at_mem[i] = 8'h00;
    for (int i = 0; i < 8192; i++) pt_mem[i] = 8'h00;
    nt_mem[11'h0C4] = 8'h11; nt_mem[11'h084] = 8'h22; nt_mem[11'h0DC] = 8'h33;
    nt_mem[11'h0DE] = 8'h44; nt_mem[11'h445] = 8'h5A; nt_mem[11'h3C3] = 8'h99;
    nt_mem[11'h3BF] = 8'h77;
    at_mem[7'h09] = 8'hA0; at_mem[7'h0F] = 8'h20; at_mem[7'h41] = 8'h1B;
    at_mem[7'h38] = 8'hFF; at_mem[7'h3F] = 8'hE4;
    pt_mem[13'h0110] = 8'h81; pt_mem[13'h0118] = 8'h7E;
    pt_mem[13'h0225] = 8'h55; pt_mem[13'h022D] = 8'hAA;
    pt_mem[13'h0330] = 8'h01; pt_mem[13'h0338] = 8'h80;
    pt_mem[13'h0440] = 8'h0F; pt_mem[13'h0448] = 8'hF0;
    pt_mem[13'h15A3] = 8'h3C; pt_mem[13'h15AB] = 8'hC3;
    pt_mem[13'h0002] = 8'hEE; pt_mem[13'h000A] = 8'hDD;
    pt_mem[13'h1777] = 8'h12; pt_mem[13'h177F] = 8'h34;

    vecs[0] = '{1'b0, 1'b0, 5'd6,  5'd4,  3'd0, 11'h0C4, 7'h09, 13'h0110, 13'h0118, 8'h11, 2'd2, 8'h81, 8'h7E, 1'b0};
    vecs[1] = '{1'b0, 1'b0, 5'd4,  5'd4,  3'd5, 11'h084, 7'h09, 13'h0225, 13'h022D, 8'h22, 2'd0, 8'h55, 8'hAA, 1'b0};
    vecs[2] = '{1'b0, 1'b0, 5'd6,  5'd28, 3'd0, 11'h0DC, 7'h0F, 13'h0330, 13'h0338, 8'h33, 2'd2, 8'h01, 8'h80, 1'b0};
    vecs[3] = '{1'b0, 1'b0, 5'd6,  5'd30, 3'd0, 11'h0DE, 7'h0F, 13'h0440, 13'h0448, 8'h44, 2'd0, 8'h0F, 8'hF0, 1'b0};
    vecs[4] = '{1'b1, 1'b1, 5'd2,  5'd5,  3'd3, 11'h445, 7'h41, 13'h15A3, 13'h15AB, 8'h5A, 2'd1, 8'h3C, 8'hC3, 1'b0};
    vecs[5] = '{1'b0, 1'b0, 5'd30, 5'd3,  3'd2, 11'h3C3, 7'h38, 13'h0002, 13'h000A, 8'h00, 2'd0, 8'h00, 8'h00, 1'b1};
    vecs[6] = '{1'b0, 1'b1, 5'd29, 5'd31, 3'd7, 11'h3BF, 7'h3F, 13'h1777, 13'h177F, 8'h77, 2'd1, 8'h12, 8'h34, 1'b0};

    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_oor", 32'(oor), 32'd0);
    check("rst_record", 32'({tile_idx, tile_pal, tile_pat_lo, tile_pat_hi}), 32'd0);
    check("rst_addr", 32'({rom_if.nt_addr, rom_if.at_addr, rom_if.pt_addr}), 32'd0);

    for (int k = 0; k < 7; k++) run_vec(vecs[k], k);

    // start held high: one fetch every 6 cycles
    nd = 0;
    for (int i = 0; i < 3; i++) done_cyc[i] = -100;
    @(negedge clk);
    nt_sel = 1'b0; pt_sel = 1'b0; tile_row = 5'd6; tile_col = 5'd4; fine_y = 3'd0;
    start = 1'b1;
    for (int c = 1; c <= 30 && nd < 3; c++) begin
      @(negedge clk);
      if (done) begin
        done_cyc[nd] = c;
        nd++;
      end
    end
    start = 1'b0;
    check("b2b_first_done", 32'(done_cyc[0]), 32'd5);
    check("b2b_spacing1", 32'(done_cyc[1] - done_cyc[0]), 32'd6);
    check("b2b_spacing2", 32'(done_cyc[2] - done_cyc[1]), 32'd6);
    $display("b2b done cycles %0d %0d %0d", done_cyc[0], done_cyc[1], done_cyc[2]);
    repeat (8) @(negedge clk);

    // reset during AT
    nt_sel = 1'b0; pt_sel = 1'b0; tile_row = 5'd6; tile_col = 5'd4; fine_y = 3'd0;
    start = 1'b1;
    @(negedge clk);  // NT
    start = 1'b0;
    @(negedge clk);  // AT
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_record", 32'({tile_idx, tile_pal, tile_pat_lo, tile_pat_hi}), 32'd0);
    check("midrst_oor", 32'(oor), 32'd0);
    check("midrst_addr", 32'({rom_if.nt_addr, rom_if.at_addr, rom_if.pt_addr}), 32'd0);
    seen_done = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      seen_done |= done | busy;
    end
    check("midrst_no_done", 32'(seen_done), 32'd0);
    $display("mid-fetch reset busy=%0d idx=%02h", busy, tile_idx);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
